instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 157 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Streams 32-bit instruction words from an upstream valid/ready source into
// a byte-wide instruction memory, one byte per cycle, little-endian.
//
// Parameters:
//   ADDR_W           byte-address width; memory depth is 2**ADDR_W bytes
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   start_i          begin a load (only looked at while idle)
//   base_addr_i      byte address of the first byte, captured with start_i
//   word_count_i     number of words to load (0..15), captured with start_i
//   in_valid_i       upstream word available
//   in_data_i        upstream instruction word
//   in_ready_o       block accepts in_data_i this cycle
//   mem_we_o         byte-write strobe
//   mem_addr_o       byte address of the write
//   mem_wdata_o      byte to write
//   busy_o           high whenever the block is not idle
//   done_o           one-cycle completion pulse
//   words_written_o  words fully written in the current or most recent load
module instr_mem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [3:0]        word_count_i,
    input  logic              in_valid_i,
    input  logic [31:0]       in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        words_written_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        idx_q;
    logic [3:0]        remaining_q;
    logic [31:0]       word_q;
    logic [3:0]        words_written_q;

    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              busy_q;
    logic              done_q;

    logic [1:0]        idx_d;
    logic [3:0]        remaining_d;
    logic [ADDR_W-1:0] addr_d;

    assign idx_d       = idx_q + 2'd1;
    assign remaining_d = remaining_q - 4'd1;
    // Word-to-word address step; wraps silently at the top of memory.
    assign addr_d      = addr_q + ADDR_W'(4);

    // The output registers are loaded with the values belonging to the
    // state being entered, so every output lines up with the state register
    // without any combinational decode on the output path. In WRITE the
    // address and data of the next byte are prepared one cycle ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            idx_q           <= '0;
            remaining_q     <= '0;
            word_q          <= '0;
            words_written_q <= '0;
            in_ready_q      <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q          <= base_addr_i;
                        remaining_q     <= word_count_i;
                        words_written_q <= '0;
                        busy_q          <= 1'b1;
                        if (word_count_i != '0) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        word_q      <= in_data_i;
                        idx_q       <= '0;
                        state_q     <= WRITE;
                        in_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= in_data_i[7:0];
                    end
                end
                WRITE: begin
                    idx_q <= idx_d;
                    if (idx_q == 2'd3) begin
                        // Last byte of the word is on the bus this cycle.
                        mem_we_q        <= 1'b0;
                        addr_q          <= addr_d;
                        remaining_q     <= remaining_d;
                        words_written_q <= words_written_q + 4'd1;
                        if (remaining_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        mem_addr_q  <= addr_q + ADDR_W'(idx_d);
                        mem_wdata_q <= word_q[8*idx_d +: 8];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign words_written_o = words_written_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. Each load is described by a
// record; a cycle-schedule model derived from the load rules (one LOAD
// cycle plus optional stall cycles, then four byte writes per word, a DONE
// cycle at the end) predicts every output cycle by cycle, and a byte-array
// image of the memory is compared against what the design wrote.
module tb_instr_mem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [3:0]        word_count_i;
    logic              in_valid_i;
    logic [31:0]       in_data_i;
    logic              in_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic [3:0]        words_written_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] obsMem [DEPTH];
    logic [7:0] expMem [DEPTH];
    int         obsWrites = 0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                count;
        int                stall;
        int                resetCycle;
        bit                useFixed;
        logic [31:0]       word0;
        int                expDone;
        int                expWritten;
        int                expBytes;
        bit                checkTable;
    } vec_t;

    vec_t vecs [8];

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .word_count_i    (word_count_i),
        .in_valid_i      (in_valid_i),
        .in_data_i       (in_data_i),
        .in_ready_o      (in_ready_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .words_written_o (words_written_o)
    );

    always #5 clk = ~clk;

    // Behaves like the byte memory attached to the loader.
    always @(posedge clk) begin
        if (mem_we_o === 1'b1) begin
            obsMem[mem_addr_o] <= mem_wdata_o;
            obsWrites          <= obsWrites + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready_o), 0);
        checkOutput({tag, " mem_we"}, 32'(mem_we_o), 0);
        checkOutput({tag, " mem_addr"}, 32'(mem_addr_o), 0);
        checkOutput({tag, " mem_wdata"}, 32'(mem_wdata_o), 0);
        checkOutput({tag, " busy"}, 32'(busy_o), 0);
        checkOutput({tag, " done"}, 32'(done_o), 0);
        checkOutput({tag, " words_written"}, 32'(words_written_o), 0);
    endtask

    // Runs one load, starting in an idle cycle. Cycle 1 is the cycle with
    // start high; the DONE cycle is 2 + count*(5+stall).
    task automatic applyStimulus(input vec_t v);
        logic [31:0]       words [16];
        logic [ADDR_W-1:0] expAddr;
        logic [7:0]        expByte;
        int period, last, endC, k, w, r, b;
        int doneCycle, writesBefore, expByteCnt, memBad, modelDone;
        bit inLoad, inWrite, isDone;

        period = 5 + v.stall;
        last   = 2 + v.count * period;
        endC   = (v.resetCycle != 0) ? v.resetCycle : last;
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        if (v.useFixed) words[0] = v.word0;
        for (int i = 0; i < DEPTH; i++) expMem[i] = obsMem[i];
        writesBefore = obsWrites;
        expByteCnt   = 0;
        doneCycle    = 0;

        for (int c = 1; c <= endC; c++) begin
            inLoad = 0; inWrite = 0; isDone = 0; w = 0; r = 0; b = 0;
            if (c == last) begin
                isDone = 1;
            end else if (c >= 2) begin
                k = c - 2;
                w = k / period;
                r = k % period;
                if (r <= v.stall) inLoad = 1;
                else begin
                    inWrite = 1;
                    b = r - v.stall - 1;
                end
            end

            reset = (c == v.resetCycle);
            if (c == 1) begin
                start_i      = 1'b1;
                base_addr_i  = v.base;
                word_count_i = v.count[3:0];
            end else begin
                start_i      = (c == last) ? 1'b1 : 1'($urandom);
                base_addr_i  = ADDR_W'($urandom);
                word_count_i = 4'($urandom);
            end
            if (inLoad && r == v.stall) begin
                in_valid_i = 1'b1;
                in_data_i  = words[w];
            end else if (inLoad) begin
                in_valid_i = 1'b0;
                in_data_i  = $urandom;
            end else begin
                in_valid_i = 1'($urandom);
                in_data_i  = $urandom;
            end

            checkOutput($sformatf("busy c%0d", c), 32'(busy_o), 32'(c >= 2));
            checkOutput($sformatf("in_ready c%0d", c), 32'(in_ready_o), 32'(inLoad));
            checkOutput($sformatf("mem_we c%0d", c), 32'(mem_we_o), 32'(inWrite));
            checkOutput($sformatf("done c%0d", c), 32'(done_o), 32'(isDone));
            if (inWrite) begin
                expAddr = ADDR_W'(int'(v.base) + 4*w + b);
                expByte = words[w][8*b +: 8];
                checkOutput($sformatf("mem_addr c%0d", c), 32'(mem_addr_o), 32'(expAddr));
                checkOutput($sformatf("mem_wdata c%0d", c), 32'(mem_wdata_o), 32'(expByte));
                expMem[expAddr] = expByte;
                expByteCnt++;
            end
            if (c >= 2)
                checkOutput($sformatf("words_written c%0d", c), 32'(words_written_o), isDone ? v.count : w);
            if (done_o === 1'b1 && doneCycle == 0) doneCycle = c;
            @(posedge clk);
            #1;
        end

        reset      = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;

        if (v.resetCycle != 0) begin
            checkIdleReset("after reset");
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                checkOutput("post-reset done", 32'(done_o), 0);
                checkOutput("post-reset mem_we", 32'(mem_we_o), 0);
                checkOutput("post-reset busy", 32'(busy_o), 0);
            end
        end else begin
            checkOutput("end busy", 32'(busy_o), 0);
            checkOutput("end done", 32'(done_o), 0);
            checkOutput("end in_ready", 32'(in_ready_o), 0);
            checkOutput("end words_written", 32'(words_written_o), v.count);
        end

        modelDone = (v.resetCycle != 0 && v.resetCycle < last) ? 0 : last;
        checkOutput("done cycle", doneCycle, modelDone);
        checkOutput("byte writes", obsWrites - writesBefore, expByteCnt);
        memBad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (obsMem[i] !== expMem[i]) memBad++;
        checkOutput("memory image bad bytes", memBad, 0);

        if (v.checkTable) begin
            checkOutput("table done cycle", doneCycle, v.expDone);
            checkOutput("table words_written", 32'(words_written_o), v.expWritten);
            checkOutput("table byte writes", obsWrites - writesBefore, v.expBytes);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        word_count_i = '0;
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkIdleReset("power-up reset");

        //           base   cnt stl rst fix   word0         done wr bytes chk
        vecs[0] = '{5'd0,  1,  0,  0,  1'b1, 32'h11090002, 7,   1,  4,  1'b1};
        vecs[1] = '{5'd30, 1,  0,  0,  1'b1, 32'hAABBCCDD, 7,   1,  4,  1'b1};
        vecs[2] = '{5'd7,  0,  0,  0,  1'b0, 32'h0,        2,   0,  0,  1'b1};
        vecs[3] = '{5'd8,  2,  3,  0,  1'b0, 32'h0,        18,  2,  8,  1'b1};
        vecs[4] = '{5'd28, 3,  0,  0,  1'b0, 32'h0,        17,  3,  12, 1'b1};
        vecs[5] = '{5'd5,  3,  0,  3,  1'b0, 32'h0,        0,   0,  1,  1'b1};
        vecs[6] = '{5'd20, 15, 1,  0,  1'b0, 32'h0,        92,  15, 60, 1'b1};
        vecs[7] = '{5'd3,  9,  2,  0,  1'b0, 32'h0,        65,  9,  36, 1'b1};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            if (i == 0) begin
                checkOutput("v0 byte@0", 32'(obsMem[0]), 32'h02);
                checkOutput("v0 byte@3", 32'(obsMem[3]), 32'h11);
            end
            if (i == 1) begin
                checkOutput("v1 byte@30", 32'(obsMem[30]), 32'hDD);
                checkOutput("v1 byte@1", 32'(obsMem[1]), 32'hAA);
            end
        end

        for (int n = 0; n < 20; n++) begin
            vec_t rv;
            rv.base       = ADDR_W'($urandom);
            rv.count      = $urandom_range(0, 15);
            rv.stall      = $urandom_range(0, 3);
            rv.resetCycle = 0;
            if (rv.count > 0 && $urandom_range(0, 3) == 0)
                rv.resetCycle = $urandom_range(2, 2 + rv.count * (5 + rv.stall));
            rv.useFixed   = 1'b0;
            rv.word0      = '0;
            rv.expDone    = 0;
            rv.expWritten = 0;
            rv.expBytes   = 0;
            rv.checkTable = 1'b0;
            applyStimulus(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
